// File: rtl/torv32_pkg.sv
// Shared torv32 definitions: reset instruction word and the grant encoding
// used to remember which requester owns the RAM read in flight.
package torv32_pkg;

    // Instruction presented on the fetch port before any fetch completes (add x0,x0,x0)
    localparam logic [31:0] NOP_WORD = 32'h0000_0033;

    // Which requester was granted the RAM in the previous cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

endpackage

// File: rtl/torv32_mem_arbiter.sv
// Shares one synchronous single-port RAM between the torv32 fetch and data
// ports. Data accesses win by default; after MAX_DATA_RUN consecutive data
// grants while a fetch is waiting, the fetch is let through once. Each read
// port keeps its last returned word in a hold register, so the value stays
// stable while that port is stalled or idle.
module torv32_mem_arbiter
    import torv32_pkg::*;
#(
    parameter int          AW           = 14,
    parameter int          MAX_DATA_RUN = 4,
    parameter logic [31:0] NOP_WORD     = torv32_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_en,
    input  logic [31:0]   i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_stall,
    input  logic          d_rd,
    input  logic [3:0]    d_wmask,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_stall,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_wmask,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    gnt_e        last_q;
    gnt_e        last_d;
    logic        i_req;
    logic        d_req;
    logic        gnt_i;
    logic        gnt_d;
    logic        run_at_max;
    logic [3:0]  run_cnt;
    logic [31:0] i_hold;
    logic [31:0] d_hold;

    // Address bits outside the word index are deliberately ignored (aliasing, byte lanes)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    assign run_at_max = (run_cnt == 4'(MAX_DATA_RUN));

    // Request decode and fixed-priority grant; nothing is granted while in reset
    always_comb begin
        i_req = i_en;
        d_req = d_rd | (|d_wmask);
        gnt_d = resetn & d_req & !(i_req & run_at_max);
        gnt_i = resetn & i_req & !gnt_d;
        i_stall = resetn & i_req & !gnt_i;
        d_stall = resetn & d_req & !gnt_d;
    end

    // Drive the RAM port from whichever requester won this cycle
    always_comb begin
        ram_en    = gnt_d | gnt_i;
        ram_addr  = gnt_d ? d_addr[AW+1:2] : i_addr[AW+1:2];
        ram_wmask = gnt_d ? d_wmask : 4'b0000;
        ram_wdata = d_wdata;
    end

    // Owner register: remembers whose read the RAM is returning this cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= GNT_NONE;
        end else begin
            last_q <= last_d;
        end
    end

    // Next owner follows the current grant
    always_comb begin
        last_d = GNT_NONE;
        if (gnt_d) begin
            last_d = GNT_D;
        end else if (gnt_i) begin
            last_d = GNT_I;
        end
    end

    // Read-data steering: fresh RAM data for the owner, held data otherwise
    always_comb begin
        i_rdata = (last_q == GNT_I) ? ram_rdata : i_hold;
        d_rdata = (last_q == GNT_D) ? ram_rdata : d_hold;
    end

    // Hold registers capture whatever each port shows, keeping it until the next grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_hold <= NOP_WORD;
            d_hold <= 32'h0;
        end else begin
            i_hold <= i_rdata;
            d_hold <= d_rdata;
        end
    end

    // Starvation guard: count data wins over a waiting fetch, saturating at 15
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_cnt <= 4'd0;
        end else if (gnt_i || !i_req) begin
            run_cnt <= 4'd0;
        end else if (gnt_d && run_cnt != 4'hF) begin
            run_cnt <= run_cnt + 4'd1;
        end
    end

endmodule
